// File: rtl/gpio_bank.sv
// gpio_bank: parametrised GPIO port with per-bit output enable, atomic
// set/clear, synchronised and debounced inputs, and edge event flags that
// raise a level interrupt.
`timescale 1ns/1ps

module gpio_bank #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DEB_BITS = 4,
   parameter int unsigned PRESCALE = 25
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sel,
   input  logic             wr,
   input  logic             rd,
   input  logic [2:0]       addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   input  logic [WIDTH-1:0] pin_i,
   output logic [WIDTH-1:0] pin_o,
   output logic [WIDTH-1:0] pin_oe,
   output logic             irq
);

   localparam int unsigned       PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
   localparam logic [DEB_BITS-1:0] CNT_ONES = '1;
   // The flip happens on the tick that would take the counter to all-ones.
   localparam logic [DEB_BITS-1:0] CNT_LAST = CNT_ONES - DEB_BITS'(1);

   localparam logic [2:0] ADDR_DATA  = 3'd0;
   localparam logic [2:0] ADDR_OE    = 3'd1;
   localparam logic [2:0] ADDR_SET   = 3'd2;
   localparam logic [2:0] ADDR_CLR   = 3'd3;
   localparam logic [2:0] ADDR_RISE  = 3'd4;
   localparam logic [2:0] ADDR_FALL  = 3'd5;
   localparam logic [2:0] ADDR_EVENT = 3'd6;
   localparam logic [2:0] ADDR_IRQEN = 3'd7;

   logic [WIDTH-1:0]    r_pin_o;
   logic [WIDTH-1:0]    r_pin_oe;
   logic [WIDTH-1:0]    r_rise_en;
   logic [WIDTH-1:0]    r_fall_en;
   logic [WIDTH-1:0]    r_irq_en;
   logic [WIDTH-1:0]    r_event;
   logic [WIDTH-1:0]    r_s1;
   logic [WIDTH-1:0]    r_s2;
   logic [WIDTH-1:0]    r_deb;
   logic [WIDTH-1:0]    r_deb_q;
   logic [DEB_BITS-1:0] r_cnt [WIDTH];
   logic [PRE_W-1:0]    r_pre;
   logic                r_irq;

   logic                w_we;
   logic [WIDTH-1:0]    w_wd;
   logic [WIDTH-1:0]    w_w1c;
   logic [WIDTH-1:0]    w_rise;
   logic [WIDTH-1:0]    w_fall;
   logic                w_tick;
   logic                w_unused;

   assign w_we     = sel & wr;
   assign w_wd     = wdata[WIDTH-1:0];
   assign w_w1c    = (w_we && (addr == ADDR_EVENT)) ? w_wd : '0;
   assign w_rise   = r_deb & ~r_deb_q & r_rise_en;
   assign w_fall   = ~r_deb & r_deb_q & r_fall_en;
   assign w_tick   = (r_pre == PRE_LAST);
   // Reads have no side effects, so the read strobe and the upper write bits are not needed.
   assign w_unused = ^{rd, wdata};

   // CPU-writable control registers and the output latch.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_pin_o   <= '0;
         r_pin_oe  <= '0;
         r_rise_en <= '0;
         r_fall_en <= '0;
         r_irq_en  <= '0;
      end else if (w_we) begin
         case (addr)
            ADDR_DATA:  r_pin_o   <= w_wd;
            ADDR_OE:    r_pin_oe  <= w_wd;
            ADDR_SET:   r_pin_o   <= r_pin_o | w_wd;
            ADDR_CLR:   r_pin_o   <= r_pin_o & ~w_wd;
            ADDR_RISE:  r_rise_en <= w_wd;
            ADDR_FALL:  r_fall_en <= w_wd;
            ADDR_IRQEN: r_irq_en  <= w_wd;
            default:    ;
         endcase
      end
   end

   // Two-flop synchroniser for the asynchronous pad inputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= pin_i;
         r_s2 <= r_s1;
      end
   end

   // Debounce tick prescaler, wraps at PRESCALE-1.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_pre <= '0;
      end else if (w_tick) begin
         r_pre <= '0;
      end else begin
         r_pre <= r_pre + PRE_W'(1);
      end
   end

   // Per-bit debounce: any return to the current level restarts the count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_deb <= '0;
         for (int i = 0; i < int'(WIDTH); i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < int'(WIDTH); i++) begin
            if (r_s2[i] != r_deb[i]) begin
               if (w_tick) begin
                  if (r_cnt[i] == CNT_LAST) begin
                     r_deb[i] <= r_s2[i];
                     r_cnt[i] <= '0;
                  end else begin
                     r_cnt[i] <= r_cnt[i] + DEB_BITS'(1);
                  end
               end
            end else begin
               r_cnt[i] <= '0;
            end
         end
      end
   end

   // Sticky edge flags; a new edge wins over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_deb_q <= '0;
         r_event <= '0;
      end else begin
         r_deb_q <= r_deb;
         r_event <= (r_event & ~w_w1c) | w_rise | w_fall;
      end
   end

   // Level interrupt from any enabled pending flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= |(r_event & r_irq_en);
      end
   end

   // Register read mux, zero-extended to the bus width.
   always_comb begin
      rdata = '0;
      case (addr)
         ADDR_DATA:  rdata = 32'(r_deb);
         ADDR_OE:    rdata = 32'(r_pin_oe);
         ADDR_SET:   rdata = 32'(r_pin_o);
         ADDR_CLR:   rdata = 32'(r_pin_o);
         ADDR_RISE:  rdata = 32'(r_rise_en);
         ADDR_FALL:  rdata = 32'(r_fall_en);
         ADDR_EVENT: rdata = 32'(r_event);
         ADDR_IRQEN: rdata = 32'(r_irq_en);
         default:    rdata = '0;
      endcase
   end

   assign pin_o  = r_pin_o;
   assign pin_oe = r_pin_oe;
   assign irq    = r_irq;

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: scoreboard bench for gpio_bank (8-, 32- and 5-bit builds).
`timescale 1ns/1ps

module tb_gpio_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic        wr;
   logic        rd;
   logic [2:0]  addr;
   logic [31:0] wdata;

   logic [31:0] rdata8, rdata32, rdata5;
   logic [7:0]  pin8_i, pin8_o, pin8_oe;
   logic [31:0] pin32_i, pin32_o, pin32_oe;
   logic [4:0]  pin5_i, pin5_o, pin5_oe;
   logic        irq8, irq32, irq5;

   logic [31:0] exp_q[$];
   logic [31:0] r8, r32, r5;
   logic [31:0] got, exp;
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   gpio_bank #(.WIDTH(8), .DEB_BITS(4), .PRESCALE(2)) u_dut (
      .clk(clk), .rst(rst), .sel(sel), .wr(wr), .rd(rd), .addr(addr),
      .wdata(wdata), .rdata(rdata8), .pin_i(pin8_i), .pin_o(pin8_o),
      .pin_oe(pin8_oe), .irq(irq8));

   gpio_bank #(.WIDTH(32), .DEB_BITS(4), .PRESCALE(2)) u_dut32 (
      .clk(clk), .rst(rst), .sel(sel), .wr(wr), .rd(rd), .addr(addr),
      .wdata(wdata), .rdata(rdata32), .pin_i(pin32_i), .pin_o(pin32_o),
      .pin_oe(pin32_oe), .irq(irq32));

   gpio_bank #(.WIDTH(5), .DEB_BITS(4), .PRESCALE(2)) u_dut5 (
      .clk(clk), .rst(rst), .sel(sel), .wr(wr), .rd(rd), .addr(addr),
      .wdata(wdata), .rdata(rdata5), .pin_i(pin5_i), .pin_o(pin5_o),
      .pin_oe(pin5_oe), .irq(irq5));

   // One write cycle; returns at the negedge after the write edge.
   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      sel = 1'b0; wr = 1'b0;
   endtask

   // Combinational read sampled mid-cycle.
   task automatic bus_read(input logic [2:0] a);
      addr = a; rd = 1'b1;
      #1;
      r8 = rdata8; r32 = rdata32; r5 = rdata5;
      rd = 1'b0;
   endtask

   // Poll DATA on the 8-bit build until it equals val, bounded.
   task automatic wait_data8(input logic [7:0] val, output bit ok, output int n);
      ok = 1'b0; n = 0;
      while (!ok && n < 60) begin
         @(negedge clk);
         n++;
         bus_read(3'd0);
         if (r8[7:0] == val) ok = 1'b1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b0; pin8_i = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         bus_write(3'd0, 32'hFF);
         bus_write(3'd1, 32'hFF);
         bus_write(3'd6, 32'h00);
      end
      @(negedge clk);
      exp_q.push_back(32'h0);  // pin_o
      exp_q.push_back(32'h0);  // pin_oe
      exp_q.push_back(32'h0);  // irq
      exp_q.push_back(32'h0);  // EVENT
      exp_q.push_back(32'h0);  // DATA
      got = 32'(pin8_o); exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL reset_pin_o got=%h exp=%h", got, exp); end
      got = 32'(pin8_oe); exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL reset_pin_oe got=%h exp=%h", got, exp); end
      got = 32'(irq8); exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL reset_irq got=%h exp=%h", got, exp); end
      bus_read(3'd6);
      got = r8; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL reset_event got=%h exp=%h", got, exp); end
      bus_read(3'd0);
      got = r8; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL reset_data got=%h exp=%h", got, exp); end
      pin8_i = 8'h00;
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_outputs;
      bus_write(3'd0, 32'hFFFF_FFA5);
      exp_q.push_back(32'hA5);
      bus_read(3'd2);
      got = r8; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL out_data got=%h exp=%h", got, exp); end

      bus_write(3'd2, 32'h0F);
      exp_q.push_back(32'hAF);
      bus_read(3'd3);
      got = r8; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL out_set got=%h exp=%h", got, exp); end

      bus_write(3'd3, 32'h81);
      exp_q.push_back(32'h2E);
      exp_q.push_back(32'h2E);
      bus_read(3'd2);
      got = r8; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL out_clr got=%h exp=%h", got, exp); end
      got = 32'(pin8_o); exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL out_pin_o got=%h exp=%h", got, exp); end

      bus_write(3'd1, 32'hF0);
      exp_q.push_back(32'hF0);
      got = 32'(pin8_oe); exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL out_oe got=%h exp=%h", got, exp); end

      // Write strobe without select must be ignored.
      @(negedge clk);
      sel = 1'b0; wr = 1'b1; addr = 3'd0; wdata = 32'h00;
      @(negedge clk);
      wr = 1'b0;
      exp_q.push_back(32'h2E);
      got = 32'(pin8_o); exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL out_nosel got=%h exp=%h", got, exp); end
   endtask

   task automatic test_debounce;
      bit ok;
      int n;
      bit seen;
      @(negedge clk);
      pin8_i = 8'h01;
      wait_data8(8'h01, ok, n);
      n_checks++;
      if (!ok || n < 30 || n > 34) begin
         n_fail++; $display("FAIL deb_latency got=%0d ok=%0d exp=30..34", n, ok);
      end
      @(negedge clk);
      pin8_i = 8'h00;
      wait_data8(8'h00, ok, n);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL deb_release got=%0d exp=<60", n); end

      // Short glitch must never reach the debounced value.
      @(negedge clk);
      pin8_i = 8'h01;
      repeat (5) @(negedge clk);
      pin8_i = 8'h00;
      seen = 1'b0;
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         bus_read(3'd0);
         if (r8[0]) seen = 1'b1;
      end
      n_checks++;
      if (seen) begin n_fail++; $display("FAIL deb_glitch got=1 exp=0"); end

      exp_q.push_back(32'h0);
      bus_read(3'd6);
      got = r8; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL deb_no_event got=%h exp=%h", got, exp); end
   endtask

   task automatic test_events;
      bit ok;
      int n;
      bus_write(3'd4, 32'h01);
      bus_write(3'd5, 32'h02);
      bus_write(3'd7, 32'h03);
      pin8_i = 8'h02;
      wait_data8(8'h02, ok, n);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL ev_setup got=%0d exp=<60", n); end
      repeat (2) @(negedge clk);
      exp_q.push_back(32'h0);
      bus_read(3'd6);
      got = r8; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL ev_unenabled got=%h exp=%h", got, exp); end

      pin8_i = 8'h01;
      wait_data8(8'h01, ok, n);
      repeat (2) @(negedge clk);
      exp_q.push_back(32'h03);
      exp_q.push_back(32'h1);
      bus_read(3'd6);
      got = r8; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL ev_both got=%h exp=%h", got, exp); end
      got = 32'(irq8); exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL ev_irq_set got=%h exp=%h", got, exp); end

      // Disabling an edge enable keeps the pending flag.
      bus_write(3'd4, 32'h00);
      bus_write(3'd6, 32'h01);
      exp_q.push_back(32'h02);
      bus_read(3'd6);
      got = r8; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL ev_w1c_bit0 got=%h exp=%h", got, exp); end
      @(negedge clk);
      exp_q.push_back(32'h1);
      got = 32'(irq8); exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL ev_irq_hold got=%h exp=%h", got, exp); end

      bus_write(3'd6, 32'h02);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h1);
      exp_q.push_back(32'h0);
      bus_read(3'd6);
      got = r8; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL ev_w1c_bit1 got=%h exp=%h", got, exp); end
      got = 32'(irq8); exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL ev_irq_lag got=%h exp=%h", got, exp); end
      @(negedge clk);
      got = 32'(irq8); exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL ev_irq_clr got=%h exp=%h", got, exp); end
      bus_write(3'd4, 32'h01);
   endtask

   task automatic test_collision;
      bit ok;
      int n;
      bit hit;
      pin8_i = 8'h00;
      wait_data8(8'h00, ok, n);
      repeat (2) @(negedge clk);
      exp_q.push_back(32'h0);
      bus_read(3'd6);
      got = r8; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL col_pre got=%h exp=%h", got, exp); end

      pin8_i = 8'h01;
      hit = 1'b0; n = 0;
      while (!hit && n < 60) begin
         @(negedge clk);
         n++;
         addr = 3'd0;
         #1;
         if (rdata8[0]) begin
            // Clear lands on the same edge that records the rise.
            hit = 1'b1;
            addr = 3'd6; wdata = 32'h01; sel = 1'b1; wr = 1'b1;
            @(negedge clk);
            sel = 1'b0; wr = 1'b0;
         end
      end
      n_checks++;
      if (!hit) begin n_fail++; $display("FAIL col_timeout got=%0d exp=<60", n); end
      exp_q.push_back(32'h01);
      bus_read(3'd6);
      got = r8; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL col_priority got=%h exp=%h", got, exp); end
      @(negedge clk);
      exp_q.push_back(32'h1);
      got = 32'(irq8); exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL col_irq got=%h exp=%h", got, exp); end

      bus_write(3'd6, 32'h01);
      exp_q.push_back(32'h0);
      bus_read(3'd6);
      got = r8; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL col_clear got=%h exp=%h", got, exp); end
   endtask

   task automatic test_width;
      bus_write(3'd1, 32'hFFFF_FFFF);
      bus_write(3'd0, 32'hDEAD_BEEF);
      exp_q.push_back(32'hDEAD_BEEF);
      exp_q.push_back(32'hFFFF_FFFF);
      got = pin32_o; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL w32_pin_o got=%h exp=%h", got, exp); end
      got = pin32_oe; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL w32_pin_oe got=%h exp=%h", got, exp); end

      for (int a = 0; a < 8; a++) bus_write(3'(a), 32'hFFFF_FFFF);
      for (int a = 0; a < 8; a++) begin
         exp_q.push_back(32'h0);
         bus_read(3'(a));
         got = r5 & 32'hFFFF_FFE0; exp = exp_q.pop_front(); n_checks++;
         if (got !== exp) begin n_fail++; $display("FAIL w5_upper a=%0d got=%h exp=%h", a, got, exp); end
      end
      exp_q.push_back(32'h1F);
      bus_read(3'd1);
      got = r5; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL w5_oe got=%h exp=%h", got, exp); end
   endtask

   initial begin
      rst = 1'b0; sel = 1'b0; wr = 1'b0; rd = 1'b0; addr = 3'd0; wdata = '0;
      pin8_i = '0; pin32_i = '0; pin5_i = '0;
      test_reset();
      test_outputs();
      test_debounce();
      test_events();
      test_collision();
      test_width();
      if (exp_q.size() != 0) begin
         n_checks++; n_fail++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
